// File: rtl/s_axis_rq_arb.sv
// Two-input, packet-atomic round-robin arbiter for PCIe requester-request TLP streams.
// Feeds a 2-entry skid buffer so the merged output is fully registered.
module s_axis_rq_arb #(
    parameter int DATA_WIDTH  = 128,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int USER_WIDTH  = 4,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                  user_clk,
    input  logic                  user_reset_n,
    input  logic [DATA_WIDTH-1:0] s0_axis_rq_tdata,
    input  logic [KEEP_WIDTH-1:0] s0_axis_rq_tkeep,
    input  logic                  s0_axis_rq_tlast,
    input  logic [USER_WIDTH-1:0] s0_axis_rq_tuser,
    input  logic                  s0_axis_rq_tvalid,
    output logic                  s0_axis_rq_tready,
    input  logic [DATA_WIDTH-1:0] s1_axis_rq_tdata,
    input  logic [KEEP_WIDTH-1:0] s1_axis_rq_tkeep,
    input  logic                  s1_axis_rq_tlast,
    input  logic [USER_WIDTH-1:0] s1_axis_rq_tuser,
    input  logic                  s1_axis_rq_tvalid,
    output logic                  s1_axis_rq_tready,
    output logic [DATA_WIDTH-1:0] m_axis_rq_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_rq_tkeep,
    output logic                  m_axis_rq_tlast,
    output logic [USER_WIDTH-1:0] m_axis_rq_tuser,
    output logic                  m_axis_rq_tvalid,
    input  logic [3:0]            m_axis_rq_tready,
    output logic [15:0]           pkt_cnt0,
    output logic [15:0]           pkt_cnt1
);

    localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;

    typedef enum logic {IDLE, GNT} state_t;

    state_t              state;
    logic                grant;
    logic                favour;
    logic [1:0]          count;
    logic [BEAT_W-1:0]   skid0;
    logic [BEAT_W-1:0]   skid1;
    logic [BEAT_W-1:0]   in_beat;
    logic                in_valid;
    logic                in_last;
    logic                in_ready;
    logic                push;
    logic                pop;
    logic                unused_tready;

    assign unused_tready = ^m_axis_rq_tready[3:1];

    assign in_beat  = grant ? {s1_axis_rq_tdata, s1_axis_rq_tkeep, s1_axis_rq_tlast, s1_axis_rq_tuser}
                            : {s0_axis_rq_tdata, s0_axis_rq_tkeep, s0_axis_rq_tlast, s0_axis_rq_tuser};
    assign in_valid = grant ? s1_axis_rq_tvalid : s0_axis_rq_tvalid;
    assign in_last  = grant ? s1_axis_rq_tlast  : s0_axis_rq_tlast;

    // Ready looks only at registered occupancy, never at the downstream ready.
    assign in_ready = (state == GNT) && (count != 2'd2);
    assign s0_axis_rq_tready = in_ready && !grant;
    assign s1_axis_rq_tready = in_ready && grant;

    assign push = in_valid && in_ready;
    assign pop  = (count != 2'd0) && m_axis_rq_tready[0];

    always_ff @(posedge user_clk) begin
        if (!user_reset_n) begin
            state    <= IDLE;
            grant    <= 1'b0;
            favour   <= 1'b0;
            pkt_cnt0 <= 16'd0;
            pkt_cnt1 <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (s0_axis_rq_tvalid || s1_axis_rq_tvalid) begin
                        state <= GNT;
                        if (s0_axis_rq_tvalid && s1_axis_rq_tvalid)
                            grant <= (ROUND_ROBIN != 0) ? favour : 1'b0;
                        else
                            grant <= s1_axis_rq_tvalid;
                    end
                end
                GNT: begin
                    if (push && in_last) begin
                        state <= IDLE;
                        if (ROUND_ROBIN != 0)
                            favour <= ~grant;
                        if (grant)
                            pkt_cnt1 <= pkt_cnt1 + 16'd1;
                        else
                            pkt_cnt0 <= pkt_cnt0 + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge user_clk) begin
        if (!user_reset_n) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // skid0 is always the head entry, so it only changes when the head is popped or filled.
    always_ff @(posedge user_clk) begin
        case ({push, pop})
            2'b10: begin
                if (count == 2'd0)
                    skid0 <= in_beat;
                else
                    skid1 <= in_beat;
            end
            2'b01: skid0 <= skid1;
            2'b11: begin
                if (count == 2'd1) begin
                    skid0 <= in_beat;
                end else begin
                    skid0 <= skid1;
                    skid1 <= in_beat;
                end
            end
            default: begin
                skid0 <= skid0;
                skid1 <= skid1;
            end
        endcase
    end

    assign {m_axis_rq_tdata, m_axis_rq_tkeep, m_axis_rq_tlast, m_axis_rq_tuser} = skid0;
    assign m_axis_rq_tvalid = (count != 2'd0);

endmodule

// File: tb/tb_s_axis_rq_arb.sv
// Bench for s_axis_rq_arb: a round-robin and a fixed-priority instance, each checked
// every cycle against a queue-level model of packet ownership and buffered beats.
module tb_s_axis_rq_arb;

    localparam int DW = 128;
    localparam int KW = 16;
    localparam int UW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    typedef struct {
        beat_t b;
        int    gap;
    } src_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] s_data  [2][2];
    logic [KW-1:0] s_keep  [2][2];
    logic          s_last  [2][2];
    logic [UW-1:0] s_user  [2][2];
    logic          s_valid [2][2];
    logic          s_ready [2][2];
    logic [DW-1:0] m_data  [2];
    logic [KW-1:0] m_keep  [2];
    logic          m_last  [2];
    logic [UW-1:0] m_user  [2];
    logic          m_valid [2];
    logic [3:0]    m_ready;
    logic [15:0]   cnt0    [2];
    logic [15:0]   cnt1    [2];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        s_axis_rq_arb #(
            .DATA_WIDTH (DW),
            .KEEP_WIDTH (KW),
            .USER_WIDTH (UW),
            .ROUND_ROBIN(k == 0 ? 1 : 0)
        ) dut (
            .user_clk         (clk),
            .user_reset_n     (reset_n),
            .s0_axis_rq_tdata (s_data[k][0]),
            .s0_axis_rq_tkeep (s_keep[k][0]),
            .s0_axis_rq_tlast (s_last[k][0]),
            .s0_axis_rq_tuser (s_user[k][0]),
            .s0_axis_rq_tvalid(s_valid[k][0]),
            .s0_axis_rq_tready(s_ready[k][0]),
            .s1_axis_rq_tdata (s_data[k][1]),
            .s1_axis_rq_tkeep (s_keep[k][1]),
            .s1_axis_rq_tlast (s_last[k][1]),
            .s1_axis_rq_tuser (s_user[k][1]),
            .s1_axis_rq_tvalid(s_valid[k][1]),
            .s1_axis_rq_tready(s_ready[k][1]),
            .m_axis_rq_tdata  (m_data[k]),
            .m_axis_rq_tkeep  (m_keep[k]),
            .m_axis_rq_tlast  (m_last[k]),
            .m_axis_rq_tuser  (m_user[k]),
            .m_axis_rq_tvalid (m_valid[k]),
            .m_axis_rq_tready (m_ready),
            .pkt_cnt0         (cnt0[k]),
            .pkt_cnt1         (cnt1[k])
        );
    end

    src_t  src_q     [2][2][$];
    beat_t exp_q     [2][$];
    int    out_order [2][$];
    bit    owned     [2];
    int    owner     [2];
    int    fav       [2];
    int    mcnt      [2][2];
    int    saw_full  [2];
    int    out_beats [2];
    bit    fire      [2][2];
    int    vectors     = 0;
    int    miscompares = 0;

    function automatic void cmp(string name, int k, logic [159:0] act, logic [159:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s inst%0d: got %h, expected %h", name, k, act, exp);
        end
    endfunction

    function automatic beat_t mk(int port, int pkt, int beat, bit last);
        beat_t b;
        b.data = {32'hA5A5_5A5A, 32'(pkt), 32'h0, 8'(port), 8'(pkt), 8'(beat), 8'(beat + 1)};
        b.keep = last ? 16'h0FFF : 16'hFFFF;
        b.last = last;
        b.user = 4'(port * 8 + beat);
        return b;
    endfunction

    function automatic void present();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) begin
                if (src_q[k][p].size() > 0 && src_q[k][p][0].gap == 0) begin
                    s_valid[k][p] = 1'b1;
                    s_data[k][p]  = src_q[k][p][0].b.data;
                    s_keep[k][p]  = src_q[k][p][0].b.keep;
                    s_last[k][p]  = src_q[k][p][0].b.last;
                    s_user[k][p]  = src_q[k][p][0].b.user;
                end else begin
                    s_valid[k][p] = 1'b0;
                    s_data[k][p]  = '0;
                    s_keep[k][p]  = '0;
                    s_last[k][p]  = 1'b0;
                    s_user[k][p]  = '0;
                end
            end
    endfunction

    // gap_beat: index of the beat preceded by gap_len cycles of deasserted valid (-1 for none).
    function automatic void load(int port, int pkt, int nbeats, int gap_beat, int gap_len);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < nbeats; i++) begin
                src_t s;
                s.b   = mk(port, pkt, i, i == nbeats - 1);
                s.gap = (i == gap_beat) ? gap_len : 0;
                src_q[k][port].push_back(s);
            end
        present();
    endfunction

    function automatic void drive();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) begin
                if (!reset_n) begin
                    src_q[k][p].delete();
                end else if (fire[k][p]) begin
                    void'(src_q[k][p].pop_front());
                end else if (src_q[k][p].size() > 0 && src_q[k][p][0].gap > 0) begin
                    src_t s = src_q[k][p][0];
                    s.gap--;
                    src_q[k][p][0] = s;
                end
            end
        present();
    endfunction

    // Model: one owner per packet, arbitration takes a cycle, buffered beats drain in order.
    function automatic void check();
        for (int k = 0; k < 2; k++) begin
            bit er [2];
            for (int p = 0; p < 2; p++)
                er[p] = owned[k] && owner[k] == p && exp_q[k].size() < 2;
            cmp("s0_tready", k, 160'(s_ready[k][0]), 160'(er[0]));
            cmp("s1_tready", k, 160'(s_ready[k][1]), 160'(er[1]));
            cmp("m_tvalid", k, 160'(m_valid[k]), 160'(exp_q[k].size() > 0));
            if (exp_q[k].size() > 0)
                cmp("m_beat", k, 160'({m_data[k], m_keep[k], m_last[k], m_user[k]}), 160'(exp_q[k][0]));
            cmp("pkt_cnt0", k, 160'(cnt0[k]), 160'(16'(mcnt[k][0])));
            cmp("pkt_cnt1", k, 160'(cnt1[k]), 160'(16'(mcnt[k][1])));
            for (int p = 0; p < 2; p++)
                fire[k][p] = s_valid[k][p] && s_ready[k][p];
            if (!reset_n) begin
                exp_q[k].delete();
                out_order[k].delete();
                owned[k]     = 1'b0;
                fav[k]       = 0;
                mcnt[k][0]   = 0;
                mcnt[k][1]   = 0;
                saw_full[k]  = 0;
                out_beats[k] = 0;
                continue;
            end
            if (exp_q[k].size() == 2)
                saw_full[k]++;
            if (exp_q[k].size() > 0 && m_ready[0]) begin
                if (exp_q[k][0].last)
                    out_order[k].push_back(int'(exp_q[k][0].data[31:24]));
                out_beats[k]++;
                void'(exp_q[k].pop_front());
            end
            if (owned[k]) begin
                int p = owner[k];
                if (s_valid[k][p] && er[p]) begin
                    beat_t b;
                    b.data = s_data[k][p];
                    b.keep = s_keep[k][p];
                    b.last = s_last[k][p];
                    b.user = s_user[k][p];
                    exp_q[k].push_back(b);
                    if (b.last) begin
                        owned[k]   = 1'b0;
                        mcnt[k][p] = (mcnt[k][p] + 1) % 65536;
                        if (k == 0)
                            fav[k] = 1 - p;
                    end
                end
            end else if (s_valid[k][0] || s_valid[k][1]) begin
                owned[k] = 1'b1;
                if (s_valid[k][0] && s_valid[k][1])
                    owner[k] = (k == 0) ? fav[k] : 0;
                else
                    owner[k] = s_valid[k][0] ? 0 : 1;
            end
        end
    endfunction

    function automatic bit idle_all();
        bit r = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (owned[k] || exp_q[k].size() > 0)
                r = 1'b0;
            for (int p = 0; p < 2; p++)
                if (src_q[k][p].size() > 0)
                    r = 1'b0;
        end
        return r;
    endfunction

    // Packet order as decimal digits, port 0 -> 1, port 1 -> 2.
    function automatic int order_code(int k);
        int c = 0;
        for (int i = 0; i < out_order[k].size(); i++)
            c = c * 10 + out_order[k][i] + 1;
        return c;
    endfunction

    task automatic tick();
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic drain(int budget, string name);
        int n = 0;
        while (!idle_all() && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        if (!idle_all()) begin
            miscompares++;
            $display("[TB] FAIL %s: traffic still pending after %0d cycles, expected drained", name, budget);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        m_ready = 4'b0001;
        present();
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            cmp("rst_m_tvalid", k, 160'(m_valid[k]), 160'(0));
            cmp("rst_s0_tready", k, 160'(s_ready[k][0]), 160'(0));
            cmp("rst_s1_tready", k, 160'(s_ready[k][1]), 160'(0));
            cmp("rst_cnt0", k, 160'(cnt0[k]), 160'(0));
            cmp("rst_cnt1", k, 160'(cnt1[k]), 160'(0));
        end
        reset_n = 1'b1;

        // Single 3-beat packet on port 0: first output beat two cycles after valid.
        load(0, 1, 3, -1, 0);
        tick();
        for (int k = 0; k < 2; k++) begin
            cmp("t1_arb_tvalid", k, 160'(m_valid[k]), 160'(0));
            cmp("t1_arb_s0_tready", k, 160'(s_ready[k][0]), 160'(1));
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            cmp("t1_first_tvalid", k, 160'(m_valid[k]), 160'(1));
            cmp("t1_first_byte", k, 160'(m_data[k][7:0]), 160'(8'h01));
        end
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            cmp("t1_last_byte", k, 160'(m_data[k][7:0]), 160'(8'h03));
            cmp("t1_last_tlast", k, 160'(m_last[k]), 160'(1));
            cmp("t1_last_tkeep", k, 160'(m_keep[k]), 160'(16'h0FFF));
            cmp("t1_cnt0", k, 160'(cnt0[k]), 160'(1));
        end
        drain(20, "t1_drain");

        // Both ports busy with two 2-beat packets each.
        apply_reset();
        load(0, 10, 2, -1, 0);
        load(0, 11, 2, -1, 0);
        load(1, 20, 2, -1, 0);
        load(1, 21, 2, -1, 0);
        drain(100, "t2_drain");
        cmp("t2_order_rr", 0, 160'(order_code(0)), 160'(1212));
        cmp("t2_order_fixed", 1, 160'(order_code(1)), 160'(1122));
        for (int k = 0; k < 2; k++) begin
            cmp("t2_cnt0", k, 160'(cnt0[k]), 160'(2));
            cmp("t2_cnt1", k, 160'(cnt1[k]), 160'(2));
        end

        // Port 0 stalls for 3 cycles mid-packet while port 1 waits.
        apply_reset();
        load(0, 30, 4, 2, 3);
        load(1, 31, 2, -1, 0);
        drain(60, "t3_drain");
        for (int k = 0; k < 2; k++)
            cmp("t3_order", k, 160'(order_code(k)), 160'(12));

        // Downstream ready toggles 1010 during a 6-beat packet; upper ready bits carry noise.
        apply_reset();
        load(0, 40, 6, -1, 0);
        for (int i = 0; i < 60 && !idle_all(); i++) begin
            m_ready = (i % 2 == 0) ? 4'b0001 : 4'b1110;
            tick();
        end
        m_ready = 4'b0001;
        drain(10, "t4_drain");
        for (int k = 0; k < 2; k++) begin
            cmp("t4_out_beats", k, 160'(out_beats[k]), 160'(6));
            cmp("t4_full_seen", k, 160'(saw_full[k] > 0), 160'(1));
        end

        // Reset during beat 2 of 4, then both ports contend.
        apply_reset();
        load(0, 50, 1, -1, 0);
        drain(20, "t5_pre_drain");
        load(1, 51, 4, -1, 0);
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            cmp("t5_m_tvalid", k, 160'(m_valid[k]), 160'(0));
            cmp("t5_s0_tready", k, 160'(s_ready[k][0]), 160'(0));
            cmp("t5_s1_tready", k, 160'(s_ready[k][1]), 160'(0));
            cmp("t5_cnt0", k, 160'(cnt0[k]), 160'(0));
            cmp("t5_cnt1", k, 160'(cnt1[k]), 160'(0));
        end
        reset_n = 1'b1;
        load(0, 52, 2, -1, 0);
        load(1, 53, 2, -1, 0);
        drain(40, "t5_drain");
        for (int k = 0; k < 2; k++) begin
            cmp("t5_order", k, 160'(order_code(k)), 160'(12));
            cmp("t5_post_cnt0", k, 160'(cnt0[k]), 160'(1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
